// File: rtl/bram_arb_pkg.sv
// Shared definitions for the BRAM frame arbiter: arbiter states, requester
// count and the bank address helper used by every bank tracker.
package bram_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_t;

  // Word address inside a requester's ping-pong pair; callers truncate to their width.
  function automatic logic [31:0] bank_addr(input logic [31:0] base,
                                            input logic        bank,
                                            input logic [31:0] size,
                                            input logic [31:0] cnt);
    return base + (bank ? size : 32'd0) + cnt;
  endfunction

endpackage

// File: rtl/bram_bank_tracker.sv
// Per-requester ping-pong bookkeeping: current bank, word counter, ready bits,
// overrun detection and the saturating dropped-frame counter.
module bram_bank_tracker
  import bram_arb_pkg::*;
#(
  parameter int                      C_ADDR_WIDTH = 12,
  parameter int                      C_BANK_SIZE  = 64,
  parameter logic [C_ADDR_WIDTH-1:0] C_BASE       = '0
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    i_start,
  input  logic                    i_acc,
  input  logic                    i_last,
  input  logic [1:0]              i_ack,
  output logic                    o_wr,
  output logic [C_ADDR_WIDTH-1:0] o_addr,
  output logic [1:0]              o_rdy,
  output logic [15:0]             o_ovr_cnt
);

  localparam int CW = $clog2(C_BANK_SIZE) + 1;

  logic          r_cur;
  logic [CW-1:0] r_cnt;
  logic          r_ovr;
  logic [1:0]    r_rdy;
  logic [15:0]   r_ovr_cnt;

  logic          w_room;
  logic          w_done;
  logic [1:0]    w_set;

  assign w_room = r_cnt < CW'(C_BANK_SIZE);
  assign o_wr   = i_acc & ~r_ovr & w_room;
  assign w_done = i_acc & i_last;
  assign w_set  = (w_done & ~r_ovr) ? (2'b01 << r_cur) : 2'b00;
  assign o_addr = C_ADDR_WIDTH'(bank_addr(32'(C_BASE), r_cur,
                                          32'(C_BANK_SIZE), 32'(r_cnt)));
  assign o_rdy     = r_rdy;
  assign o_ovr_cnt = r_ovr_cnt;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_cur     <= 1'b0;
      r_cnt     <= '0;
      r_ovr     <= 1'b0;
      r_rdy     <= 2'b00;
      r_ovr_cnt <= '0;
    end else begin
      // Overrun is decided once per frame: the target bank must be free at grant.
      if (i_start) begin
        r_cnt <= '0;
        r_ovr <= r_rdy[r_cur];
      end else if (o_wr) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_done & ~r_ovr)
        r_cur <= ~r_cur;
      if (w_done & r_ovr & (r_ovr_cnt != 16'hFFFF))
        r_ovr_cnt <= r_ovr_cnt + 16'd1;
      // A completing frame beats a simultaneous ack of the same bank.
      r_rdy <= (r_rdy & ~i_ack) | w_set;
    end
  end

endmodule

// File: rtl/bram_frame_arbiter.sv
// Round-robin frame arbiter for the shared 16-bit BRAM write port; one
// bank tracker per requester, registered BRAM outputs and level IRQ.
module bram_frame_arbiter
  import bram_arb_pkg::*;
#(
  parameter int                      C_ADDR_WIDTH = 12,
  parameter int                      C_BANK_SIZE  = 64,
  parameter logic [C_ADDR_WIDTH-1:0] C_BASE0      = 12'h000,
  parameter logic [C_ADDR_WIDTH-1:0] C_BASE1      = 12'h080
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    r0_req,
  output logic                    r0_gnt,
  input  logic                    r0_valid,
  input  logic [15:0]             r0_data,
  input  logic                    r0_last,
  input  logic                    r1_req,
  output logic                    r1_gnt,
  input  logic                    r1_valid,
  input  logic [15:0]             r1_data,
  input  logic                    r1_last,
  output logic                    bram_clk,
  output logic                    bram_rst,
  output logic [C_ADDR_WIDTH-1:0] bram_addr,
  output logic                    bram_en,
  output logic [1:0]              bram_we,
  output logic [15:0]             bram_din,
  input  logic [3:0]              bank_ack,
  output logic [3:0]              bank_rdy,
  output logic                    irq,
  output logic [15:0]             ovr_cnt0,
  output logic [15:0]             ovr_cnt1
);

  arb_state_t                               r_state;
  logic                                     r_ptr;
  logic [NUM_REQ-1:0]                       r_gnt;
  logic                                     r_irq;
  logic                                     r_en;
  logic [C_ADDR_WIDTH-1:0]                  r_addr;
  logic [15:0]                              r_din;

  logic [NUM_REQ-1:0]                       w_req, w_valid, w_last;
  logic [NUM_REQ-1:0]                       w_start, w_acc, w_wr;
  logic [NUM_REQ-1:0][15:0]                 w_data;
  logic [NUM_REQ-1:0][C_ADDR_WIDTH-1:0]     w_addr;
  logic [NUM_REQ-1:0][1:0]                  w_rdy;
  logic [NUM_REQ-1:0][15:0]                 w_ovr;

  assign w_req   = {r1_req, r0_req};
  assign w_valid = {r1_valid, r0_valid};
  assign w_last  = {r1_last, r0_last};
  assign w_data  = {r1_data, r0_data};
  assign w_acc   = r_gnt & w_valid;

  // r_ptr names the requester that wins a tie; it points away from the last grant.
  always_comb begin
    w_start = '0;
    if (r_state == ST_IDLE) begin
      if (&w_req) w_start[r_ptr] = 1'b1;
      else        w_start = w_req;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
      r_ptr   <= 1'b0;
      r_gnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start[0]) begin
            r_state <= ST_GNT0;
            r_gnt   <= 2'b01;
            r_ptr   <= 1'b1;
          end else if (w_start[1]) begin
            r_state <= ST_GNT1;
            r_gnt   <= 2'b10;
            r_ptr   <= 1'b0;
          end
        end
        ST_GNT0: begin
          if (w_acc[0] & w_last[0]) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
          end
        end
        ST_GNT1: begin
          if (w_acc[1] & w_last[1]) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_trk
    bram_bank_tracker #(
      .C_ADDR_WIDTH (C_ADDR_WIDTH),
      .C_BANK_SIZE  (C_BANK_SIZE),
      .C_BASE       ((g == 0) ? C_BASE0 : C_BASE1)
    ) u_trk (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .i_start   (w_start[g]),
      .i_acc     (w_acc[g]),
      .i_last    (w_last[g]),
      .i_ack     (bank_ack[2*g +: 2]),
      .o_wr      (w_wr[g]),
      .o_addr    (w_addr[g]),
      .o_rdy     (w_rdy[g]),
      .o_ovr_cnt (w_ovr[g])
    );
  end

  // Grants are exclusive, so at most one tracker asks to write per cycle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_en   <= 1'b0;
      r_addr <= '0;
      r_din  <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_en  <= |w_wr;
      r_irq <= |w_rdy;
      if (w_wr[1]) begin
        r_addr <= w_addr[1];
        r_din  <= w_data[1];
      end else if (w_wr[0]) begin
        r_addr <= w_addr[0];
        r_din  <= w_data[0];
      end
    end
  end

  assign r0_gnt    = r_gnt[0];
  assign r1_gnt    = r_gnt[1];
  assign bram_clk  = aclk;
  assign bram_rst  = ~aresetn;
  assign bram_en   = r_en;
  assign bram_we   = {2{r_en}};
  assign bram_addr = r_addr;
  assign bram_din  = r_din;
  assign bank_rdy  = w_rdy;
  assign irq       = r_irq;
  assign ovr_cnt0  = w_ovr[0];
  assign ovr_cnt1  = w_ovr[1];

endmodule

// File: tb/tb_bram_frame_arbiter.sv
// Directed bench for bram_frame_arbiter: inputs change and outputs are checked
// on the falling edge; expected values are hand-derived.
module tb_bram_frame_arbiter;

  logic             aclk = 1'b0;
  logic             aresetn;
  logic [1:0]       req, valid, last;
  logic [1:0][15:0] data;
  logic [1:0]       gnt;
  logic             bram_clk, bram_rst, bram_en, irq;
  logic [11:0]      bram_addr;
  logic [1:0]       bram_we;
  logic [15:0]      bram_din, ovr0, ovr1;
  logic [3:0]       bank_ack, bank_rdy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 aclk = ~aclk;

  bram_frame_arbiter dut (
    .aclk(aclk), .aresetn(aresetn),
    .r0_req(req[0]), .r0_gnt(gnt[0]), .r0_valid(valid[0]), .r0_data(data[0]), .r0_last(last[0]),
    .r1_req(req[1]), .r1_gnt(gnt[1]), .r1_valid(valid[1]), .r1_data(data[1]), .r1_last(last[1]),
    .bram_clk(bram_clk), .bram_rst(bram_rst), .bram_addr(bram_addr), .bram_en(bram_en),
    .bram_we(bram_we), .bram_din(bram_din), .bank_ack(bank_ack), .bank_rdy(bank_rdy),
    .irq(irq), .ovr_cnt0(ovr0), .ovr_cnt1(ovr1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_gnt"},  gnt, 0);
    chk({tag, "_en"},   bram_en, 0);
    chk({tag, "_we"},   bram_we, 0);
    chk({tag, "_addr"}, bram_addr, 0);
    chk({tag, "_din"},  bram_din, 0);
    chk({tag, "_rdy"},  bank_rdy, 0);
    chk({tag, "_irq"},  irq, 0);
    chk({tag, "_ovr"},  {ovr1, ovr0}, 0);
  endtask

  task automatic do_reset();
    aresetn = 1'b0; req = '0; valid = '0; last = '0; data = '0; bank_ack = '0;
    #1;
    chk_idle_outputs("rst");
    chk("rst_bram_rst", bram_rst, 1);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
  endtask

  // Request, then require the grant on the very next cycle.
  task automatic request(input int n);
    req[n] = 1'b1;
    @(negedge aclk);
    chk("req_to_gnt", gnt[n], 1);
  endtask

  // Drive one frame; each word's write must show up one cycle after acceptance.
  task automatic send_frame(input int n, input int nw, input int dbase, input int abase,
                            input int maxw, input bit hold, input logic [3:0] ack_last);
    int k = 0;
    while (!gnt[n] && k < 20) begin @(negedge aclk); k++; end
    chk("gnt_wait", gnt[n], 1);
    for (int i = 0; i < nw; i++) begin
      valid[n] = 1'b1;
      data[n]  = 16'(dbase + i);
      last[n]  = (i == nw - 1);
      if (i == nw - 1) begin
        req[n]   = hold;
        bank_ack = ack_last;
      end
      @(negedge aclk);
      bank_ack = '0;
      chk("wr_en", bram_en, (i < maxw));
      if (i < maxw) begin
        chk("wr_we",   bram_we, 2'b11);
        chk("wr_addr", bram_addr, abase + i);
        chk("wr_din",  bram_din, 16'(dbase + i));
      end
    end
    valid[n] = 1'b0;
    last[n]  = 1'b0;
    chk("release", gnt[n], 0);
  endtask

  task automatic ack(input logic [3:0] a);
    bank_ack = a;
    @(negedge aclk);
    bank_ack = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Single frame into r0 bank 0; irq follows rdy by one cycle.
    request(0);
    send_frame(0, 40, 16'h1000, 0, 64, 0, 4'b0000);
    chk("t1_rdy", bank_rdy, 4'b0001);
    chk("t1_irq_early", irq, 0);
    @(negedge aclk);
    chk("t1_irq", irq, 1);

    // Second frame lands in bank 1, third is an overrun.
    request(0);
    send_frame(0, 40, 16'h2000, 64, 64, 0, 4'b0000);
    chk("t2_rdy", bank_rdy, 4'b0011);
    request(0);
    send_frame(0, 5, 16'h2100, 0, 0, 0, 4'b0000);
    chk("t2_ovr0", ovr0, 1);
    chk("t2_ovr1", ovr1, 0);
    chk("t2_rdy_keep", bank_rdy, 4'b0011);
    ack(4'b0001);
    chk("t2_ack0", bank_rdy, 4'b0010);
    chk("t2_irq_hold", irq, 1);
    ack(4'b0010);
    chk("t2_ack1", bank_rdy, 4'b0000);
    chk("t2_irq_lag", irq, 1);
    @(negedge aclk);
    chk("t2_irq_clr", irq, 0);
    request(0);
    send_frame(0, 3, 16'h2200, 0, 64, 0, 4'b0000);
    chk("t2_after_ovr", bank_rdy, 4'b0001);

    // Contention from reset: r0, then r1, then r0 again with reqs held.
    do_reset();
    req = 2'b11;
    @(negedge aclk);
    chk("t3_first", gnt, 2'b01);
    send_frame(0, 4, 16'h3000, 0, 64, 1, 4'b0000);
    chk("t3_gap", gnt, 2'b00);
    @(negedge aclk);
    chk("t3_second", gnt, 2'b10);
    send_frame(1, 4, 16'h3100, 128, 64, 1, 4'b0000);
    @(negedge aclk);
    chk("t3_third", gnt, 2'b01);
    req[1] = 1'b0;
    send_frame(0, 2, 16'h3200, 64, 64, 0, 4'b0000);
    chk("t3_rdy", bank_rdy, 4'b0111);
    @(negedge aclk);
    chk("t3_idle", gnt, 2'b00);

    // Ack and set of the same bit in one cycle: set wins.
    do_reset();
    request(1);
    send_frame(1, 3, 16'h4000, 128, 64, 0, 4'b0100);
    chk("t4_collide", bank_rdy, 4'b0100);
    ack(4'b1000);
    chk("t4_ack_clear_bit", bank_rdy, 4'b0100);
    ack(4'b0100);
    chk("t4_ack", bank_rdy, 4'b0000);

    // Oversized frame: only one bank's worth is written.
    do_reset();
    request(1);
    send_frame(1, 70, 16'h5000, 128, 64, 0, 4'b0000);
    chk("t5_rdy", bank_rdy, 4'b0100);
    chk("t5_ovr1", ovr1, 0);

    // Reset mid-frame, then restart from bank 0 address 0.
    do_reset();
    request(0);
    for (int i = 0; i < 10; i++) begin
      valid[0] = 1'b1;
      data[0]  = 16'(16'h6000 + i);
      @(negedge aclk);
    end
    chk("t6_mid_en", bram_en, 1);
    aresetn = 1'b0;
    valid = '0; req = '0;
    #1;
    chk_idle_outputs("t6_abort");
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    request(0);
    send_frame(0, 2, 16'h6100, 0, 64, 0, 4'b0000);
    chk("t6_rdy", bank_rdy, 4'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
